// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: sizing functions and the status flag bundle.
// Used by the single-clock FIFO and the async FIFO variant.
package fifo_pkg;

    // Ceiling log2 for sizing counters and addresses.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of storage entries for a given address width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w_of(input int addr_w);
        return addr_w + 1;
    endfunction

    // Occupancy status bundle.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module sync_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port: store the word at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the addressed word; hold when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy flags and sticky error flags
// around a dual-port storage array with a registered read port.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = depth_of(ADDR_W) - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = ptr_w_of(ADDR_W);
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] occ;
    logic             wr_acc;
    logic             rd_acc;
    fifo_flags_t      flags;

    // Occupancy is the modular pointer difference; the wrap bit
    // disambiguates full from empty.
    assign occ    = w_ptr - r_ptr;
    assign wr_acc = w_en && !flags.full;
    assign rd_acc = r_en && !flags.empty;

    // Status flags decoded from the registered pointers only.
    always_comb begin
        flags              = '0;
        flags.empty        = (w_ptr == r_ptr);
        flags.full         = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                             (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
        flags.almost_full  = (occ >= AF_LVL);
        flags.almost_empty = (occ <= AE_LVL);
    end

    assign count        = occ;
    assign full         = flags.full;
    assign almost_full  = flags.almost_full;
    assign empty        = flags.empty;
    assign almost_empty = flags.almost_empty;

    // Pointer advance on accepted accesses; rejected ones change nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Read-valid marks the cycle the popped word appears on r_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_acc;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && flags.full) begin
                overflow <= 1'b1;
            end
            if (r_en && flags.empty) begin
                underflow <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (w_ptr[ADDR_W-1:0]),
        .wdata (w_data),
        .re    (rd_acc),
        .raddr (r_ptr[ADDR_W-1:0]),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a queue model and an
// expected-read scoreboard; DEPTH=4, AF=3, AE=1.
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          r_en = 1'b0;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_last = '0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .w_data       (w_data),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [DW-1:0] e;
        n = mq.size();
        chk({tag, ":count"}, 32'(count), 32'(n));
        chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ":afull"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ":rvalid"}, 32'(r_valid), 32'(m_rv));
        if (m_rv) begin
            if (exp_q.size() == 0) begin
                chk({tag, ":sb_empty"}, 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                m_last = e;
                chk({tag, ":rdata"}, 32'(r_data), 32'(e));
            end
        end else begin
            chk({tag, ":rhold"}, 32'(r_data), 32'(m_last));
        end
    endtask

    task automatic step(input string tag, input logic w,
                        input logic [DW-1:0] wd, input logic r);
        bit wa;
        bit ra;
        @(negedge clk);
        w_en = w;
        w_data = wd;
        r_en = r;
        wa = w && (mq.size() < DEPTH);
        ra = r && (mq.size() > 0);
        if (w && mq.size() == DEPTH) m_ovf = 1'b1;
        if (r && mq.size() == 0) m_unf = 1'b1;
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(wd);
        m_rv = ra;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles, input logic w, input logic r);
        @(negedge clk);
        rst = 1'b1;
        w_en = w;
        r_en = r;
        w_data = 8'hEE;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv = 1'b0;
        m_last = '0;
        check_all("reset");
        chk("reset:rdata0", 32'(r_data), 32'h0);
    endtask

    initial begin
        // 1. reset
        do_reset(2, 1'b0, 1'b0);

        // 2. fill and drain
        step("fill1", 1'b1, 8'hA1, 1'b0);
        step("fill2", 1'b1, 8'hA2, 1'b0);
        step("fill3", 1'b1, 8'hA3, 1'b0);
        chk("fill3:af_rise", 32'(almost_full), 32'h1);
        step("fill4", 1'b1, 8'hA4, 1'b0);
        chk("fill4:full", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1);
            chk("drain:word", 32'(r_data), 32'(8'hA1 + i));
        end
        chk("drain:empty", 32'(empty), 32'h1);

        // 3. overflow
        for (int i = 0; i < 4; i++) begin
            step("refill", 1'b1, 8'(8'hA1 + i), 1'b0);
        end
        step("ovf_wr", 1'b1, 8'hFF, 1'b0);
        chk("ovf:sticky", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("ovf_drain", 1'b0, 8'h00, 1'b1);
            chk("ovf_drain:word", 32'(r_data), 32'(8'hA1 + i));
        end

        // 4. underflow
        step("unf_rd", 1'b0, 8'h00, 1'b1);
        chk("unf:hold", 32'(r_data), 32'hA4);
        step("unf_wr_rd", 1'b1, 8'h55, 1'b1);
        step("unf_read55", 1'b0, 8'h00, 1'b1);
        chk("unf:word55", 32'(r_data), 32'h55);

        // 5. wrap and concurrent access
        do_reset(1, 1'b0, 1'b0);
        step("pre0", 1'b1, 8'h10, 1'b0);
        step("pre1", 1'b1, 8'h11, 1'b0);
        for (int i = 2; i < 10; i++) begin
            step("stream", 1'b1, 8'(8'h10 + i), 1'b1);
            chk("stream:word", 32'(r_data), 32'(8'h10 + i - 2));
        end
        step("top0", 1'b1, 8'h20, 1'b0);
        step("top1", 1'b1, 8'h21, 1'b0);
        step("full_wr_rd", 1'b1, 8'h99, 1'b1);
        chk("full_wr_rd:count", 32'(count), 32'h3);
        chk("full_wr_rd:word", 32'(r_data), 32'h18);
        for (int i = 0; i < 3; i++) begin
            step("wrap_drain", 1'b0, 8'h00, 1'b1);
        end

        // 6. mid-operation reset
        step("mid0", 1'b1, 8'h31, 1'b0);
        step("mid1", 1'b1, 8'h32, 1'b0);
        step("mid2", 1'b1, 8'h33, 1'b0);
        do_reset(1, 1'b1, 1'b1);
        step("post_wr", 1'b1, 8'h77, 1'b0);
        step("post_rd", 1'b0, 8'h00, 1'b1);
        chk("post:word77", 32'(r_data), 32'h77);
        step("idle", 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
